rom_reader: RTL and testbench
=============================

# rom_reader

Read-side sequencer for the coefficient ROM. On a `start` pulse it walks `len` consecutive ROM addresses from `base_addr`, wrapping modulo 2^AW. The ROM's fixed one-cycle read latency is absorbed in a 2-entry buffer, and the words leave as a valid/ready stream with `m_last` marking the final word. It sits between the ROM macro and any downstream consumer that may apply backpressure.

## Interface
- AW, 3, ROM address width (2^AW words)
- DW, 4, ROM data width
- DEPTH, 2, output buffer entries; also the maximum number of outstanding reads plus buffered words
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  AW  first address; sampled with `start`
- len  in  AW+1  number of words, 0..2^AW; sampled with `start`
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse when a request completes
- rom_en  out  1  read strobe to ROM
- rom_addr  out  AW  read address, valid while `rom_en`
- rom_data  in  DW  ROM output, valid exactly one cycle after `rom_en`
- m_valid  out  1  output word available
- m_ready  in  1  consumer accepts the word
- m_data  out  DW  output word
- m_last  out  1  qualifies the final word of a request

## Operation
- FSM states:
  - IDLE:
    - `start` with len==0: pulse `done` next cycle, stay IDLE.
    - `start` with len>0: latch base_addr/len into addr/remaining, go to ISSUE.
  - ISSUE: one read is issued per cycle when `occ + inflight - pop < DEPTH`.
    - pop = m_valid && m_ready; occ = buffer occupancy; inflight = read issued last cycle.
    - Each issue: `rom_en`=1, `rom_addr`=addr, addr <= addr+1 (modulo 2^AW), remaining <= remaining-1.
    - The issue that takes remaining to 0 tags that read as last, and the FSM goes to DRAIN.
  - DRAIN: when the last-tagged word is popped, go to IDLE and pulse `done` in the following cycle.
- Each inflight read carries its last tag. The word and tag are written into the buffer at the clock edge one cycle after `rom_en`.
- The buffer presents {m_last, m_data} in FIFO order. `m_data`/`m_last` hold stable while `m_valid && !m_ready`.
- `start` is ignored while busy.
- Reset values: rom_en=0, rom_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. The buffer is empty and inflight is cleared.
- Reset asserted mid-request aborts it with no `done` and no further words. A `start` after reset release runs normally.

## Timing
- `start` accepted at edge 0: first `rom_en` in cycle 1.
- First word written at edge 2; `m_valid` high in cycle 2+1, i.e. cycle 3 (start to first `m_valid` = 3 cycles).
- With `m_ready` held high: one word per cycle, with no gaps between words.
- `done` asserts in the cycle after the last handshake. `busy` falls in that same cycle.
- Backpressure: outstanding reads plus buffered words never exceed DEPTH, so no word is ever dropped.
- After `m_ready` rises again, issue resumes in the same cycle, because the popped word frees a slot that cycle.

## Structure
- Package `rom_rd_pkg`: state enum {IDLE, ISSUE, DRAIN} and the DEPTH constant.
- Sub-module `rom_rd_fifo`:
  - 2-entry synchronous FIFO, DW+1 bits wide.
  - Same clock and reset as the top.
  - Outputs occ/full/empty.
  - Same-cycle push and pop is allowed when full.
- The bench ROM model holds `rom[i] = 2*i` and has one-cycle registered read.

## Test plan
- base=2, len=4, m_ready=1:
  - rom_addr 2,3,4,5 in cycles 1-4.
  - m_data 4,6,8,10 in cycles 3-6, m_last only on 10.
  - `done` in cycle 7.
- Wrap, base=6, len=4: addresses 6,7,0,1; data 12,14,0,2; m_last on 2.
- Backpressure, base=0, len=8, m_ready=0 for 5 cycles after the first m_valid:
  - m_valid stays high with m_data=0 stable.
  - At most 2 `rom_en` issued.
  - After release, all 8 words 0..14 arrive in order with no loss.
- len=0: `done` in cycle 1 after start; no `rom_en`, no `m_valid`, busy stays 0.
- Start while busy: a second `start` mid-request (base=5) is ignored. The output sequence matches the first request only.
- Reset mid-request: rst_n low during the 3rd word.
  - All outputs return to reset values immediately.
  - No `done` pulse.
  - A subsequent base=1, len=2 request yields 2,4.

Source files
------------

// File: rtl/rom_rd_pkg.sv
// Shared types and constants for the coefficient ROM read sequencer.
package rom_rd_pkg;

  localparam int unsigned RD_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rd_state_e;

endpackage

// File: rtl/rom_rd_fifo.sv
// Small synchronous FIFO that absorbs ROM read data ahead of the output stream.
module rom_rd_fifo
  import rom_rd_pkg::*;
#(
  parameter int unsigned W     = 5,
  parameter int unsigned DEPTH = RD_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [OW-1:0] occ_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (occ_q == OW'(DEPTH));
  assign empty   = (occ_q == '0);
  assign occ     = occ_q;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_q <= ptr_inc(rd_q);
      end
      occ_q <= occ_q + OW'(do_push) - OW'(do_pop);
    end
  end

endmodule

// File: rtl/rom_reader.sv
// Walks a run of ROM addresses and streams the words out as valid/ready with a last flag.
module rom_reader
  import rom_rd_pkg::*;
#(
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 4,
  parameter int unsigned DEPTH = RD_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned RW = AW + 1;

  rd_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          done_q, done_d;
  logic          inflight_q, inflight_last_q;
  logic          issue, last_issue, pop, slots_ok;
  logic [OW-1:0] occ;
  logic          full, empty;
  logic [DW:0]   rd_word;

  assign m_valid    = !empty;
  assign pop        = m_valid && m_ready;
  assign m_data     = rd_word[DW-1:0];
  assign m_last     = rd_word[DW];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign rom_en     = issue;
  assign rom_addr   = addr_q;
  assign last_issue = (rem_q == RW'(1));
  // Count the word leaving this cycle as already gone so issue never stalls on a pop.
  assign slots_ok   = (32'(occ) + 32'(inflight_q)) < (DEPTH + 32'(pop));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = base_addr;
            rem_d   = len;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (slots_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - RW'(1);
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && last_issue;
    end
  end

  rom_rd_fifo #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .wdata ({inflight_last_q, rom_data}),
    .pop   (pop),
    .rdata (rd_word),
    .occ   (occ),
    .full  (full),
    .empty (empty)
  );

  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_q && full && !pop));

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader against a rom[i] = 2*i model with one-cycle read.
module tb_rom_reader;

  logic       clk = 1'b0;
  logic       rst_n, start, busy, done, rom_en, m_valid, m_ready, m_last;
  logic [2:0] base_addr, rom_addr;
  logic [3:0] len;
  logic [3:0] rom_data = 4'd0;
  logic [3:0] m_data;

  int vectors = 0;
  int miscompares = 0;

  rom_reader #(.AW(3), .DW(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= {rom_addr, 1'b0};

  // Inputs change at +1 after an edge, outputs are sampled at +2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [2:0] b, input logic [3:0] l);
    start = 1'b1; base_addr = b; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({rom_en, rom_addr, m_valid, m_data, m_last, busy, done} !== 12'd0) begin
      $display("FAIL reset_values: got %h required 000",
               {rom_en, rom_addr, m_valid, m_data, m_last, busy, done});
      miscompares++;
    end
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    vectors++;
    if ({rom_en, m_valid, busy, done} !== 4'd0) begin
      $display("FAIL after_release: got %b required 0000", {rom_en, m_valid, busy, done});
      miscompares++;
    end
    tick();
  endtask

  task automatic test_basic();
    logic [2:0]  exp_addr [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
    logic [3:0]  exp_data [4] = '{4'd4, 4'd6, 4'd8, 4'd10};
    logic [11:0] got, exp;
    m_ready = 1'b1;
    start_req(3'd2, 4'd4);
    for (int c = 1; c <= 8; c++) begin
      #1;
      exp = '0;
      if (c <= 4) exp[11:8] = {1'b1, exp_addr[c-1]};
      if (c >= 3 && c <= 6) exp[7:3] = {1'b1, exp_data[c-3]};
      exp[2] = (c == 6);
      exp[1] = (c == 7);
      exp[0] = (c <= 6);
      got = {rom_en, rom_en ? rom_addr : 3'd0, m_valid, m_valid ? m_data : 4'd0, m_last, done, busy};
      vectors++;
      if (got !== exp) begin
        $display("FAIL basic_cycle%0d: got %h required %h", c, got, exp);
        miscompares++;
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_addr [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [3:0] exp_data [4] = '{4'd12, 4'd14, 4'd0, 4'd2};
    logic [2:0] addrs [8];
    logic [3:0] words [8];
    logic       lasts [8];
    int na = 0, nw = 0;
    bit got_last = 0;
    m_ready = 1'b1;
    start_req(3'd6, 4'd4);
    for (int k = 0; k < 30 && !got_last; k++) begin
      #1;
      if (rom_en && na < 8) begin addrs[na] = rom_addr; na++; end
      if (m_valid && m_ready && nw < 8) begin
        words[nw] = m_data; lasts[nw] = m_last; nw++;
        if (m_last) got_last = 1;
      end
      tick();
    end
    vectors++;
    if (na != 4 || nw != 4) begin
      $display("FAIL wrap_counts: got %0d reads %0d words required 4 4", na, nw);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (addrs[i] !== exp_addr[i] || words[i] !== exp_data[i] || lasts[i] !== (i == 3)) begin
        $display("FAIL wrap_word%0d: got addr %0d data %0d last %b required %0d %0d %b",
                 i, addrs[i], words[i], lasts[i], exp_addr[i], exp_data[i], (i == 3));
        miscompares++;
      end
    end
    #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL wrap_done: got done %b busy %b required 1 0", done, busy);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] words [8];
    logic       lasts [8];
    int issued = 0, nw = 0;
    bit got_last = 0;
    m_ready = 1'b0;
    start_req(3'd0, 4'd8);
    for (int c = 1; c <= 7; c++) begin
      #1;
      if (rom_en) issued++;
      if (c >= 3) begin
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 4'd0) begin
          $display("FAIL stall_cycle%0d: got valid %b data %0d required 1 0", c, m_valid, m_data);
          miscompares++;
        end
      end
      tick();
    end
    vectors++;
    if (issued > 2) begin
      $display("FAIL stall_issue: got %0d reads required at most 2", issued);
      miscompares++;
    end
    m_ready = 1'b1;
    for (int k = 0; k < 40 && !got_last; k++) begin
      #1;
      if (m_valid && m_ready && nw < 8) begin
        words[nw] = m_data; lasts[nw] = m_last; nw++;
        if (m_last) got_last = 1;
      end
      tick();
    end
    vectors++;
    if (nw != 8) begin
      $display("FAIL bp_count: got %0d words required 8", nw);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (i < nw && (words[i] !== 4'(2 * i) || lasts[i] !== (i == 7))) begin
        $display("FAIL bp_word%0d: got data %0d last %b required %0d %b",
                 i, words[i], lasts[i], 2 * i, (i == 7));
        miscompares++;
      end
    end
    #1;
    vectors++;
    if (done !== 1'b1) begin
      $display("FAIL bp_done: got %b required 1", done);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_len_zero();
    m_ready = 1'b1;
    start_req(3'd3, 4'd0);
    #1;
    vectors++;
    if ({done, busy, rom_en, m_valid} !== 4'b1000) begin
      $display("FAIL len0_cycle1: got %b required 1000", {done, busy, rom_en, m_valid});
      miscompares++;
    end
    tick();
    for (int c = 2; c <= 4; c++) begin
      #1;
      vectors++;
      if ({done, busy, rom_en, m_valid} !== 4'b0000) begin
        $display("FAIL len0_cycle%0d: got %b required 0000", c, {done, busy, rom_en, m_valid});
        miscompares++;
      end
      tick();
    end
  endtask

  task automatic test_start_busy();
    logic [3:0] words [4];
    logic [3:0] exp_data [3] = '{4'd6, 4'd8, 4'd10};
    int nw = 0;
    bit got_last = 0;
    m_ready = 1'b1;
    start_req(3'd3, 4'd3);
    start_req(3'd5, 4'd2);
    for (int k = 0; k < 30 && !got_last; k++) begin
      #1;
      if (m_valid && m_ready && nw < 4) begin
        words[nw] = m_data; nw++;
        if (m_last) got_last = 1;
      end
      tick();
    end
    vectors++;
    if (nw != 3) begin
      $display("FAIL busy_count: got %0d words required 3", nw);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (words[i] !== exp_data[i]) begin
        $display("FAIL busy_word%0d: got %0d required %0d", i, words[i], exp_data[i]);
        miscompares++;
      end
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if ({busy, rom_en, m_valid} !== 3'b000) begin
        $display("FAIL busy_quiet%0d: got %b required 000", c, {busy, rom_en, m_valid});
        miscompares++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] words [4];
    int nw = 0;
    bit got_last = 0, stray = 0;
    m_ready = 1'b1;
    start_req(3'd0, 4'd8);
    for (int c = 1; c <= 4; c++) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rom_en, rom_addr, m_valid, m_data, m_last, busy, done} !== 12'd0) begin
      $display("FAIL midreset_values: got %h required 000",
               {rom_en, rom_addr, m_valid, m_data, m_last, busy, done});
      miscompares++;
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (done || m_valid || rom_en || busy) stray = 1;
      tick();
    end
    vectors++;
    if (stray) begin
      $display("FAIL midreset_quiet: got activity after abort required none");
      miscompares++;
    end
    start_req(3'd1, 4'd2);
    for (int k = 0; k < 20 && !got_last; k++) begin
      #1;
      if (m_valid && m_ready && nw < 4) begin
        words[nw] = m_data; nw++;
        if (m_last) got_last = 1;
      end
      tick();
    end
    vectors++;
    if (nw != 2 || words[0] !== 4'd2 || words[1] !== 4'd4) begin
      $display("FAIL postreset_words: got %0d words %0d %0d required 2 words 2 4",
               nw, words[0], words[1]);
      miscompares++;
    end
    #1;
    vectors++;
    if (done !== 1'b1) begin
      $display("FAIL postreset_done: got %b required 1", done);
      miscompares++;
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_start_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
